// File: rtl/video_pkg.sv
// Shared constants and FSM state type for the line prefetcher.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package video_pkg;
    localparam int PIXEL_W    = 16;
    localparam int ADDR_W     = 20;
    localparam int SKID_DEPTH = 4;
    localparam int VPOS_W     = 10;
    localparam int IDX_W      = ADDR_W - VPOS_W;
    localparam int SKID_PTR_W = $clog2(SKID_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/line_prefetcher_sync2.sv
// Two-flop synchronizer, width-parameterized (module sync2).
// Latency: 2 i_clk cycles from input change to o_q.
// Backpressure: none.
// Ports: i_clk, i_rst (sync active-high), i_d (async in), o_q (synchronized out).
module sync2 #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/line_prefetcher.sv
// Fetches one video line of pixel words from memory into a dual-clock FIFO on each hsync.
// Latency: first memRdReq 3 clk100 cycles after hsync reaches the synchronizer input.
// Backpressure: fifoFull stalls the 4-entry skid; requests are throttled so inflight+skid <= 4.
// Ports: clk100/rst (sync active-high); hsync, nextFrameActive, nextVPos (async video side);
//        memAddr/memRdReq -> memRdData/memRdValid (fixed MEM_LATENCY); fifoData/fifoWrreq/fifoFull;
//        busy (line in progress), overrun (one-cycle pulse on an ignored trigger).
// Build option: TEST_PATTERN_EN replaces memory reads with a (pixel + line) mod 1024 pattern.
module line_prefetcher
    import video_pkg::*;
#(
    parameter int LINE_PIXELS = 800,
    parameter int MEM_LATENCY = 2
) (
    input  logic               clk100,
    input  logic               rst,
    input  logic               hsync,
    input  logic               nextFrameActive,
    input  logic [VPOS_W-1:0]  nextVPos,
    output logic [ADDR_W-1:0]  memAddr,
    output logic               memRdReq,
    input  logic [PIXEL_W-1:0] memRdData,
    input  logic               memRdValid,
    output logic [PIXEL_W-1:0] fifoData,
    output logic               fifoWrreq,
    input  logic               fifoFull,
    output logic               busy,
    output logic               overrun
);
    logic [1:0]            w_ctl_s;
    logic [VPOS_W-1:0]     w_vpos_s;
    logic                  r_hs_d;
    logic                  w_trig;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [VPOS_W-1:0]     r_vline;
    logic [IDX_W-1:0]      r_req_idx;
    logic [SKID_PTR_W:0]   r_inflight;
    logic [MEM_LATENCY-1:0] r_rd_pipe;

    logic [PIXEL_W-1:0]    r_skid [SKID_DEPTH];
    logic [SKID_PTR_W-1:0] r_wr_ptr;
    logic [SKID_PTR_W-1:0] r_rd_ptr;
    logic [SKID_PTR_W:0]   r_skid_cnt;

    logic [SKID_PTR_W+1:0] w_occ;
    logic                  w_issue;
    logic                  w_mem_req;
    logic                  w_accept;
    logic                  w_push;
    logic [PIXEL_W-1:0]    w_push_dat;
    logic                  w_pop;
    logic                  w_done;

    sync2 #(.W(2)) u_sync_ctl (
        .i_clk (clk100),
        .i_rst (rst),
        .i_d   ({hsync, nextFrameActive}),
        .o_q   (w_ctl_s)
    );

    sync2 #(.W(VPOS_W)) u_sync_vpos (
        .i_clk (clk100),
        .i_rst (rst),
        .i_d   (nextVPos),
        .o_q   (w_vpos_s)
    );

    assign w_trig = w_ctl_s[1] & ~r_hs_d & w_ctl_s[0];

    // Reserve a skid slot for every outstanding read so returning data never overflows.
    assign w_occ   = {1'b0, r_inflight} + {1'b0, r_skid_cnt};
    assign w_issue = (r_state == ST_FETCH) && (w_occ < (SKID_PTR_W+2)'(SKID_DEPTH));

    // Only returns lining up with a request tracked since the last reset are accepted,
    // so reads launched before a reset are dropped on arrival.
    assign w_accept = memRdValid & r_rd_pipe[MEM_LATENCY-1];

`ifdef TEST_PATTERN_EN
    logic [IDX_W-1:0] w_pat;
    assign w_pat      = r_req_idx + IDX_W'(r_vline);
    assign w_mem_req  = 1'b0;
    assign w_push     = w_issue;
    assign w_push_dat = PIXEL_W'(w_pat);
`else
    assign w_mem_req  = w_issue;
    assign w_push     = w_accept;
    assign w_push_dat = memRdData;
`endif

    assign w_pop  = (r_skid_cnt != '0) && !fifoFull && !rst;
    assign w_done = (r_inflight == '0) && (r_skid_cnt == '0);

    assign memRdReq  = w_mem_req & ~rst;
    assign memAddr   = memRdReq ? {r_vline, r_req_idx} : '0;
    assign fifoWrreq = w_pop;
    assign fifoData  = w_pop ? r_skid[r_rd_ptr] : '0;

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        overrun     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trig) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                busy    = 1'b1;
                overrun = w_trig;
                if (w_issue && (r_req_idx == IDX_W'(LINE_PIXELS - 1))) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy    = !w_done;
                overrun = w_trig;
                if (w_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (rst) begin
            busy    = 1'b0;
            overrun = 1'b0;
        end
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_hs_d     <= 1'b0;
            r_vline    <= '0;
            r_req_idx  <= '0;
            r_inflight <= '0;
            r_rd_pipe  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_skid_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hs_d  <= w_ctl_s[1];

            if ((r_state == ST_IDLE) && w_trig) begin
                r_vline   <= w_vpos_s;
                r_req_idx <= '0;
            end else if (w_issue) begin
                r_req_idx <= r_req_idx + 1'b1;
            end

            r_rd_pipe[0] <= w_mem_req;
            for (int i = 1; i < MEM_LATENCY; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];

            case ({w_mem_req, w_accept})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase

            if (w_push) begin
                r_skid[r_wr_ptr] <= w_push_dat;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_skid_cnt <= r_skid_cnt + 1'b1;
                2'b01:   r_skid_cnt <= r_skid_cnt - 1'b1;
                default: r_skid_cnt <= r_skid_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_line_prefetcher.sv
// Bench for line_prefetcher: memory responder, random FIFO backpressure, expected-word queue.
module tb_line_prefetcher;
    localparam int LP = 800;
    localparam int ML = 2;

    logic        clk100 = 1'b0;
    logic        rst;
    logic        hsync;
    logic        nextFrameActive;
    logic [9:0]  nextVPos;
    logic [19:0] memAddr;
    logic        memRdReq;
    logic [15:0] memRdData;
    logic        memRdValid;
    logic [15:0] fifoData;
    logic        fifoWrreq;
    logic        fifoFull;
    logic        busy;
    logic        overrun;

    always #5 clk100 = ~clk100;

    line_prefetcher #(.LINE_PIXELS(LP), .MEM_LATENCY(ML)) dut (
        .clk100          (clk100),
        .rst             (rst),
        .hsync           (hsync),
        .nextFrameActive (nextFrameActive),
        .nextVPos        (nextVPos),
        .memAddr         (memAddr),
        .memRdReq        (memRdReq),
        .memRdData       (memRdData),
        .memRdValid      (memRdValid),
        .fifoData        (fifoData),
        .fifoWrreq       (fifoWrreq),
        .fifoFull        (fifoFull),
        .busy            (busy),
        .overrun         (overrun)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          h_v [ML];
    logic [15:0] h_d [ML];
    logic [15:0] exp_q [$];
    logic [9:0]  cur_v;
    int          line_reqs, line_wr, ovr_cnt, first_req_cyc;
    int          stall_left = 0;
    int          full_prob = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs just after the rising edge, observe at the falling edge.
    task automatic tick();
        @(posedge clk100);
        #1;
        cyc++;
        memRdValid = h_v[ML-1];
        memRdData  = h_d[ML-1];
        if (stall_left > 0) begin
            fifoFull = 1'b1;
            stall_left--;
        end else begin
            fifoFull = (full_prob != 0) && ($urandom_range(99) < full_prob);
        end
        @(negedge clk100);
        for (int i = ML - 1; i > 0; i--) begin
            h_v[i] = h_v[i-1];
            h_d[i] = h_d[i-1];
        end
        h_v[0] = memRdReq;
        h_d[0] = memAddr[15:0];
        if (rst) begin
            chk("outputs_in_reset", {memAddr, memRdReq, fifoData, fifoWrreq, busy, overrun}, 64'd0);
        end else begin
`ifdef TEST_PATTERN_EN
            chk("no_memrdreq_pattern", memRdReq, 0);
`else
            if (memRdReq) begin
                line_reqs++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                chk("mem_addr", memAddr, {cur_v, 10'(line_reqs - 1)});
            end
            chk("occupancy_le4", (line_reqs - line_wr) <= 4, 1);
`endif
            if (fifoWrreq) begin
                chk("wr_while_full", fifoFull, 0);
                chk("wr_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("fifo_data", fifoData, exp_q.pop_front());
                line_wr++;
            end
            if (overrun) ovr_cnt++;
        end
    endtask

    task automatic run_line(input logic [9:0] v, input int stall_at, input int ovr_at, input int rst_at);
        int          c0;
        int          ovr_drop;
        bit          stalled;
        bit          ovr_done;
        logic [19:0] a;
        nextVPos      = v;
        cur_v         = v;
        line_reqs     = 0;
        line_wr       = 0;
        ovr_cnt       = 0;
        first_req_cyc = -1;
        stalled       = 0;
        ovr_done      = 0;
        ovr_drop      = -1;
        for (int n = 0; n < LP; n++) begin
`ifdef TEST_PATTERN_EN
            exp_q.push_back(16'((n + int'(v)) % 1024));
`else
            a = {v, 10'(n)};
            exp_q.push_back(a[15:0]);
`endif
        end
        nextFrameActive = 1'b1;
        hsync = 1'b1;
        c0 = cyc;
        for (int t = 0; t < 6000; t++) begin
            tick();
            if (t == 6) hsync = 1'b0;
            if (t == 3) chk("busy_after_trigger", busy, 1);
            if (stall_at >= 0 && line_wr == stall_at && !stalled) begin
                stall_left = 50;
                stalled = 1;
            end
            if (ovr_at >= 0 && line_wr == ovr_at && !ovr_done) begin
                hsync = 1'b1;
                ovr_done = 1;
                ovr_drop = t + 6;
            end
            if (t == ovr_drop) hsync = 1'b0;
            if (rst_at >= 0 && line_wr == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                exp_q.delete();
                for (int k = 0; k < 10; k++) begin
                    tick();
                    chk("post_reset_idle_req", memRdReq, 0);
                    chk("post_reset_idle_busy", busy, 0);
                end
                chk("post_reset_no_writes", line_wr, rst_at);
                return;
            end
            if (line_wr == LP && !busy) break;
        end
        for (int k = 0; k < 5; k++) tick();
        chk("line_write_count", line_wr, LP);
        chk("busy_low_after_line", busy, 0);
        chk("expected_queue_empty", exp_q.size(), 0);
        chk("overrun_pulses", ovr_cnt, (ovr_at >= 0) ? 1 : 0);
`ifndef TEST_PATTERN_EN
        chk("first_req_latency_le4", (first_req_cyc >= 0) && (first_req_cyc - c0 <= 4), 1);
        chk("line_req_count", line_reqs, LP);
`endif
    endtask

    initial begin
        rst = 1'b1;
        hsync = 1'b0;
        nextFrameActive = 1'b0;
        nextVPos = '0;
        memRdValid = 1'b0;
        memRdData = '0;
        fifoFull = 1'b0;
        for (int i = 0; i < ML; i++) begin
            h_v[i] = 1'b0;
            h_d[i] = '0;
        end
        for (int k = 0; k < 3; k++) tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) tick();

        // Plain line at vPos 5: data 0x1400..0x171F (or pattern 5..804).
        full_prob = 0;
        run_line(10'd5, -1, -1, -1);

        // 50-cycle FIFO stall mid-line.
        run_line(10'($urandom_range(1023)), 200, -1, -1);

        // Second hsync edge while fetching.
        run_line(10'($urandom_range(1023)), -1, 100, -1);

        // Trigger outside the visible frame is ignored.
        nextVPos = 10'd7;
        nextFrameActive = 1'b0;
        hsync = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("inactive_no_req", memRdReq, 0);
            chk("inactive_busy", busy, 0);
        end
        hsync = 1'b0;
        for (int k = 0; k < 4; k++) tick();

        // Reset at pixel 300, then a clean line.
        run_line(10'd9, -1, -1, 300);
        run_line(10'd12, -1, -1, -1);

        // Wrap line and random backpressure.
        full_prob = 30;
        run_line(10'd1000, -1, -1, -1);
        for (int r = 0; r < 2; r++) run_line(10'($urandom_range(1023)), -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
